ddp_rx_parse: RTL and testbench

Receive-side DDP layer: accepts framed 256-bit packet beats from the lower transport, checks and strips the DDP/RDMAP header beat, forwards payload beats to the placement buffer tagged with the queue number, and hands the parsed header plus measured payload length up to RDMAP. It is the inbound counterpart of the DDP transmit path (header gen / assemble / cut) and sits between the transport receive FIFO and the RDMAP receive engine.

---
 rtl/ddp_rx_parse.sv | 226 ++++++++++++++++++++++
 tb/tb_ddp_rx_parse.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddp_rx_parse.sv
// Receive-side DDP parser: validates and strips the header beat, forwards payload
// beats to placement tagged with the queue number, and reports the header plus length to RDMAP.
module ddp_rx_parse #(
    parameter int          MAX_BYTES = 16384,
    parameter logic [1:0]  DDP_VER   = 2'b01
) (
    input  logic         clock_i,
    input  logic         reset_i,
    input  logic         rxValid_i,
    output logic         rxReady_o,
    input  logic [255:0] rxData_i,
    input  logic         rxSop_i,
    input  logic         rxEop_i,
    input  logic [5:0]   rxBytes_i,
    input  logic         placeFull_i,
    output logic         placePush_o,
    output logic [255:0] placeData_o,
    output logic [3:0]   placeQN_o,
    output logic         placeLast_o,
    output logic         ddpRx2RdmapHdrValid_o,
    input  logic         rdmapRxHdrReady_i,
    output logic [7:0]   ddpRx2RdmapCtrl_o,
    output logic [55:0]  ddpRx2RdmapHeader_o,
    output logic [7:0]   ddpRx2RdmapDdpCtrl_o,
    output logic [15:0]  ddpRx2RdmapLen_o,
    output logic         ddpRxErr_o,
    output logic [2:0]   ddpRxErrCode_o,
    output logic [15:0]  ddpRxPktCnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_REPORT = 2'd2,
        ST_DROP   = 2'd3
    } state_t;

    localparam logic [2:0]  ERR_VER    = 3'd1;
    localparam logic [2:0]  ERR_NOSOP  = 3'd2;
    localparam logic [2:0]  ERR_ABORT  = 3'd3;
    localparam logic [2:0]  ERR_LENGTH = 3'd4;
    localparam logic [16:0] MAX_LEN    = 17'(MAX_BYTES);

    state_t         state_q, state_d;
    logic [7:0]     ddp_ctrl_q, ddp_ctrl_d;
    logic [7:0]     rdmap_ctrl_q, rdmap_ctrl_d;
    logic [55:0]    rdmap_hdr_q, rdmap_hdr_d;
    logic [3:0]     qn_q, qn_d;
    logic [15:0]    len_q, len_d;
    logic           push_q, push_d;
    logic [255:0]   pdata_q, pdata_d;
    logic [3:0]     pqn_q, pqn_d;
    logic           plast_q, plast_d;
    logic           hv_q, hv_d;
    logic           err_q, err_d;
    logic [2:0]     code_q, code_d;
    logic [15:0]    cnt_q, cnt_d;

    logic           accept_s;
    logic           take_hdr_s;
    logic           ver_ok_s;
    logic           over_s;
    logic [16:0]    beat_len_s;
    logic [16:0]    sum_len_s;

    assign rxReady_o  = !reset_i && ((state_q == ST_IDLE) || (state_q == ST_DROP) ||
                                     ((state_q == ST_DATA) && !placeFull_i));
    assign accept_s   = rxValid_i && rxReady_o;
    assign ver_ok_s   = (rxData_i[1:0] == DDP_VER);
    // One bit wider than the length register so the limit check itself cannot wrap.
    assign beat_len_s = rxEop_i ? {11'd0, rxBytes_i} : 17'd32;
    assign sum_len_s  = {1'b0, len_q} + beat_len_s;
    assign over_s     = (sum_len_s > MAX_LEN);

    // Next-state and next-output computation for the parser.
    always_comb begin
        state_d      = state_q;
        ddp_ctrl_d   = ddp_ctrl_q;
        rdmap_ctrl_d = rdmap_ctrl_q;
        rdmap_hdr_d  = rdmap_hdr_q;
        qn_d         = qn_q;
        len_d        = len_q;
        push_d       = 1'b0;
        pdata_d      = pdata_q;
        pqn_d        = pqn_q;
        plast_d      = 1'b0;
        hv_d         = hv_q;
        err_d        = 1'b0;
        code_d       = 3'd0;
        cnt_d        = cnt_q;
        take_hdr_s   = 1'b0;

        case (state_q)
            ST_IDLE, ST_DROP: begin
                if (accept_s) begin
                    if (rxSop_i) begin
                        take_hdr_s = 1'b1;
                    end else if (state_q == ST_IDLE) begin
                        err_d  = 1'b1;
                        code_d = ERR_NOSOP;
                    end else if (rxEop_i) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DROP;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_DATA: begin
                if (accept_s) begin
                    if (rxSop_i) begin
                        // Abandon the open packet; the new sop beat is its own header.
                        err_d      = 1'b1;
                        code_d     = ERR_ABORT;
                        take_hdr_s = 1'b1;
                    end else if (over_s) begin
                        err_d   = 1'b1;
                        code_d  = ERR_LENGTH;
                        state_d = rxEop_i ? ST_IDLE : ST_DROP;
                    end else begin
                        push_d  = 1'b1;
                        pdata_d = rxData_i;
                        pqn_d   = qn_q;
                        plast_d = rxEop_i;
                        len_d   = sum_len_s[15:0];
                        if (rxEop_i) begin
                            state_d = ST_REPORT;
                            hv_d    = 1'b1;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_REPORT: begin
                if (rdmapRxHdrReady_i) begin
                    hv_d    = 1'b0;
                    cnt_d   = cnt_q + 16'd1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_REPORT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (take_hdr_s) begin
            ddp_ctrl_d   = rxData_i[7:0];
            rdmap_ctrl_d = rxData_i[15:8];
            rdmap_hdr_d  = rxData_i[71:16];
            qn_d         = rxData_i[75:72];
            len_d        = 16'd0;
            if (!ver_ok_s) begin
                // An abort already flagged this cycle keeps its code.
                if (!err_d) begin
                    err_d  = 1'b1;
                    code_d = ERR_VER;
                end else begin
                    err_d  = 1'b1;
                end
                state_d = rxEop_i ? ST_IDLE : ST_DROP;
            end else if (rxEop_i) begin
                state_d = ST_REPORT;
                hv_d    = 1'b1;
            end else begin
                state_d = ST_DATA;
            end
        end else begin
            take_hdr_s = 1'b0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            ddp_ctrl_q   <= 8'd0;
            rdmap_ctrl_q <= 8'd0;
            rdmap_hdr_q  <= 56'd0;
            qn_q         <= 4'd0;
            len_q        <= 16'd0;
            push_q       <= 1'b0;
            pdata_q      <= 256'd0;
            pqn_q        <= 4'd0;
            plast_q      <= 1'b0;
            hv_q         <= 1'b0;
            err_q        <= 1'b0;
            code_q       <= 3'd0;
            cnt_q        <= 16'd0;
        end else begin
            state_q      <= state_d;
            ddp_ctrl_q   <= ddp_ctrl_d;
            rdmap_ctrl_q <= rdmap_ctrl_d;
            rdmap_hdr_q  <= rdmap_hdr_d;
            qn_q         <= qn_d;
            len_q        <= len_d;
            push_q       <= push_d;
            pdata_q      <= pdata_d;
            pqn_q        <= pqn_d;
            plast_q      <= plast_d;
            hv_q         <= hv_d;
            err_q        <= err_d;
            code_q       <= code_d;
            cnt_q        <= cnt_d;
        end
    end

    assign placePush_o           = push_q;
    assign placeData_o           = pdata_q;
    assign placeQN_o             = pqn_q;
    assign placeLast_o           = plast_q;
    assign ddpRx2RdmapHdrValid_o = hv_q;
    assign ddpRx2RdmapCtrl_o     = rdmap_ctrl_q;
    assign ddpRx2RdmapHeader_o   = rdmap_hdr_q;
    assign ddpRx2RdmapDdpCtrl_o  = ddp_ctrl_q;
    assign ddpRx2RdmapLen_o      = len_q;
    assign ddpRxErr_o            = err_q;
    assign ddpRxErrCode_o        = code_q;
    assign ddpRxPktCnt_o         = cnt_q;

endmodule

// File: tb/tb_ddp_rx_parse.sv
// Bench for ddp_rx_parse: directed and random packets against a beat-stream reference model.
module tb_ddp_rx_parse;

    logic         clock, reset;
    logic         rxValid0, rxValid1, rxValid;
    logic [255:0] rxData;
    logic         rxSop, rxEop;
    logic [5:0]   rxBytes;
    logic         placeFull, rdmapReady;
    logic         sel;

    logic         rdy0, push0, last0, hv0, err0;
    logic [255:0] data0;
    logic [3:0]   qn0;
    logic [7:0]   rc0, dc0;
    logic [55:0]  hdr0;
    logic [15:0]  len0, cnt0;
    logic [2:0]   code0;
    logic         rdy1, push1, last1, hv1, err1;
    logic [255:0] data1;
    logic [3:0]   qn1;
    logic [7:0]   rc1, dc1;
    logic [55:0]  hdr1;
    logic [15:0]  len1, cnt1;
    logic [2:0]   code1;

    assign rxValid0 = rxValid && !sel;
    assign rxValid1 = rxValid && sel;

    ddp_rx_parse dut (
        .clock_i(clock), .reset_i(reset), .rxValid_i(rxValid0), .rxReady_o(rdy0),
        .rxData_i(rxData), .rxSop_i(rxSop), .rxEop_i(rxEop), .rxBytes_i(rxBytes),
        .placeFull_i(placeFull), .placePush_o(push0), .placeData_o(data0), .placeQN_o(qn0),
        .placeLast_o(last0), .ddpRx2RdmapHdrValid_o(hv0), .rdmapRxHdrReady_i(rdmapReady),
        .ddpRx2RdmapCtrl_o(rc0), .ddpRx2RdmapHeader_o(hdr0), .ddpRx2RdmapDdpCtrl_o(dc0),
        .ddpRx2RdmapLen_o(len0), .ddpRxErr_o(err0), .ddpRxErrCode_o(code0), .ddpRxPktCnt_o(cnt0));

    ddp_rx_parse #(.MAX_BYTES(64)) dut_s (
        .clock_i(clock), .reset_i(reset), .rxValid_i(rxValid1), .rxReady_o(rdy1),
        .rxData_i(rxData), .rxSop_i(rxSop), .rxEop_i(rxEop), .rxBytes_i(rxBytes),
        .placeFull_i(placeFull), .placePush_o(push1), .placeData_o(data1), .placeQN_o(qn1),
        .placeLast_o(last1), .ddpRx2RdmapHdrValid_o(hv1), .rdmapRxHdrReady_i(rdmapReady),
        .ddpRx2RdmapCtrl_o(rc1), .ddpRx2RdmapHeader_o(hdr1), .ddpRx2RdmapDdpCtrl_o(dc1),
        .ddpRx2RdmapLen_o(len1), .ddpRxErr_o(err1), .ddpRxErrCode_o(code1), .ddpRxPktCnt_o(cnt1));

    wire          m_rdy  = sel ? rdy1  : rdy0;
    wire          m_push = sel ? push1 : push0;
    wire [255:0]  m_data = sel ? data1 : data0;
    wire [3:0]    m_qn   = sel ? qn1   : qn0;
    wire          m_last = sel ? last1 : last0;
    wire          m_hv   = sel ? hv1   : hv0;
    wire [7:0]    m_rc   = sel ? rc1   : rc0;
    wire [7:0]    m_dc   = sel ? dc1   : dc0;
    wire [55:0]   m_hdr  = sel ? hdr1  : hdr0;
    wire [15:0]   m_len  = sel ? len1  : len0;
    wire          m_err  = sel ? err1  : err0;
    wire [2:0]    m_code = sel ? code1 : code0;
    wire [15:0]   m_cnt  = sel ? cnt1  : cnt0;

    typedef struct { logic [255:0] d; logic [3:0] qn; logic last; } push_t;
    typedef struct { logic [7:0] dc; logic [7:0] rc; logic [55:0] h; logic [15:0] len; } rep_t;

    push_t      exp_push[$];
    rep_t       exp_rep[$];
    int         exp_err[$];

    int         checks = 0, failures = 0;
    int         full_mode = 0, rdy_mode = 0;
    bit         mon_en = 0;
    int         push_cnt = 0, rep_cnt = 0, last_err = 0;
    logic [15:0] last_len = 16'd0;
    logic [15:0] exp_cnt = 16'd0;

    // Reference model: which packet the stream is in (0 none, 1 open, 2 discarding).
    int         pk_mode = 0;
    int         pk_len = 0;
    rep_t       pk_hdr;
    logic [3:0] pk_qn;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] d;
        for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom();
        return d;
    endfunction

    function automatic logic [255:0] mk_hdr(input logic [1:0] ver, input logic [3:0] qn);
        logic [255:0] d;
        d = rand256();
        d[1:0]   = ver;
        d[75:72] = qn;
        return d;
    endfunction

    task automatic model_beat(input logic [255:0] d, input logic s, input logic e, input logic [5:0] b);
        int max_b;
        int add;
        rep_t r;
        max_b = sel ? 64 : 16384;
        if (s) begin
            if (pk_mode == 1) exp_err.push_back(3);
            pk_hdr.dc = d[7:0];
            pk_hdr.rc = d[15:8];
            pk_hdr.h  = d[71:16];
            pk_qn     = d[75:72];
            pk_len    = 0;
            if (d[1:0] != 2'b01) begin
                if (pk_mode != 1) exp_err.push_back(1);
                pk_mode = e ? 0 : 2;
            end else if (e) begin
                r = pk_hdr; r.len = 16'd0;
                exp_rep.push_back(r);
                pk_mode = 0;
            end else begin
                pk_mode = 1;
            end
        end else if (pk_mode == 0) begin
            exp_err.push_back(2);
        end else if (pk_mode == 2) begin
            if (e) pk_mode = 0;
        end else begin
            add = e ? int'(b) : 32;
            if (pk_len + add > max_b) begin
                exp_err.push_back(4);
                pk_mode = e ? 0 : 2;
            end else begin
                exp_push.push_back('{d: d, qn: pk_qn, last: e});
                pk_len += add;
                if (e) begin
                    r = pk_hdr; r.len = 16'(pk_len);
                    exp_rep.push_back(r);
                    pk_mode = 0;
                end
            end
        end
    endtask

    // RDMAP header-ready driver, updated just after each rising edge.
    initial begin
        rdmapReady = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            case (rdy_mode)
                0:       rdmapReady = 1'b1;
                1:       rdmapReady = 1'($urandom_range(0, 1));
                default: rdmapReady = 1'b0;
            endcase
        end
    end

    // Output monitor: compares pushes, errors and reports with the model queues.
    always @(negedge clock) begin
        if (mon_en) begin
            if (m_push) begin
                if (exp_push.size() == 0) check("push_unexpected", 256'd1, 256'd0);
                else begin
                    check("push_data", m_data, exp_push[0].d);
                    check("push_qn", 256'(m_qn), 256'(exp_push[0].qn));
                    check("push_last", 256'(m_last), 256'(exp_push[0].last));
                    void'(exp_push.pop_front());
                    push_cnt++;
                end
            end
            if (m_err) begin
                if (exp_err.size() == 0) check("err_unexpected", 256'd1, 256'd0);
                else begin
                    check("err_code", 256'(m_code), 256'(exp_err[0]));
                    last_err = int'(m_code);
                    void'(exp_err.pop_front());
                end
            end
            if (m_hv) begin
                check("report_rxready", 256'(m_rdy), 256'd0);
                if (exp_rep.size() == 0) check("report_unexpected", 256'd1, 256'd0);
                else begin
                    check("rep_ddpctrl", 256'(m_dc), 256'(exp_rep[0].dc));
                    check("rep_rctrl", 256'(m_rc), 256'(exp_rep[0].rc));
                    check("rep_header", 256'(m_hdr), 256'(exp_rep[0].h));
                    check("rep_len", 256'(m_len), 256'(exp_rep[0].len));
                    if (rdmapReady) begin
                        check("pkt_cnt", 256'(m_cnt), 256'(exp_cnt));
                        exp_cnt  = exp_cnt + 16'd1;
                        last_len = exp_rep[0].len;
                        rep_cnt++;
                        void'(exp_rep.pop_front());
                    end
                end
            end
        end
    end

    // Presents one beat and holds it until accepted; entered and left at a falling edge.
    task automatic drive_beat(input logic [255:0] d, input logic s, input logic e, input logic [5:0] b);
        int  n;
        bit  done;
        bit  acc;
        n = 0; done = 0;
        rxData = d; rxSop = s; rxEop = e; rxBytes = b; rxValid = 1'b1;
        while (!done) begin
            case (full_mode)
                0:       placeFull = 1'b0;
                1:       placeFull = ~placeFull;
                default: placeFull = 1'($urandom_range(0, 1));
            endcase
            #1;
            acc = m_rdy;
            @(posedge clock);
            if (acc) begin
                model_beat(d, s, e, b);
                done = 1;
            end else begin
                n++;
                if (n > 300) begin
                    check("accept_timeout", 256'd0, 256'd1);
                    done = 1;
                end
            end
            @(negedge clock);
        end
        rxValid = 1'b0;
        placeFull = 1'b0;
    endtask

    task automatic send_pkt(input logic [1:0] ver, input logic [3:0] qn, input int npay,
                            input logic [5:0] lastb, input bit term);
        drive_beat(mk_hdr(ver, qn), 1'b1, term && (npay == 0), lastb);
        for (int i = 1; i <= npay; i++)
            drive_beat(rand256(), 1'b0, term && (i == npay), lastb);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_rep.size() != 0 || m_hv) && n < 1000) begin
            @(negedge clock);
            n++;
        end
        if (n >= 1000) check("idle_timeout", 256'd0, 256'd1);
        repeat (3) @(negedge clock);
        check("push_drained", 256'(exp_push.size()), 256'd0);
        check("err_drained", 256'(exp_err.size()), 256'd0);
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        reset = 1'b1;
        rxValid = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_rxready", 256'(m_rdy), 256'd0);
        check("rst_push", 256'(m_push), 256'd0);
        check("rst_data", m_data, 256'd0);
        check("rst_qn", 256'(m_qn), 256'd0);
        check("rst_last", 256'(m_last), 256'd0);
        check("rst_hv", 256'(m_hv), 256'd0);
        check("rst_hdr", 256'({m_rc, m_hdr, m_dc}), 256'd0);
        check("rst_len", 256'(m_len), 256'd0);
        check("rst_err", 256'({m_err, m_code}), 256'd0);
        check("rst_cnt", 256'(m_cnt), 256'd0);
        exp_push.delete(); exp_rep.delete(); exp_err.delete();
        pk_mode = 0; pk_len = 0; exp_cnt = 16'd0;
        reset = 1'b0;
        #1;
        check("rst_release_rxready", 256'(m_rdy), 256'd1);
        mon_en = 1'b1;
    endtask

    initial begin
        int p0, r0;
        reset = 1'b1; rxValid = 1'b0; rxData = 256'd0; rxSop = 1'b0; rxEop = 1'b0;
        rxBytes = 6'd0; placeFull = 1'b0; sel = 1'b0;
        @(negedge clock);
        do_reset();

        // Good 3-beat packet.
        p0 = push_cnt;
        send_pkt(2'b01, 4'd5, 2, 6'd10, 1'b1);
        wait_idle();
        check("t1_len", 256'(last_len), 256'd42);
        check("t1_pushes", 256'(push_cnt - p0), 256'd2);
        check("t1_cnt", 256'(m_cnt), 256'd1);

        // Header-only packet with RDMAP stalled for 5 cycles.
        p0 = push_cnt;
        rdy_mode = 2;
        drive_beat(mk_hdr(2'b01, 4'd9), 1'b1, 1'b1, 6'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("t2_hv_held", 256'(m_hv), 256'd1);
            check("t2_rxready", 256'(m_rdy), 256'd0);
        end
        rdy_mode = 0;
        wait_idle();
        check("t2_len", 256'(last_len), 256'd0);
        check("t2_pushes", 256'(push_cnt - p0), 256'd0);

        // Bad version, then a good packet.
        p0 = push_cnt; r0 = rep_cnt;
        send_pkt(2'b10, 4'd2, 3, 6'd32, 1'b1);
        wait_idle();
        check("t3_code", 256'(last_err), 256'd1);
        check("t3_pushes", 256'(push_cnt - p0), 256'd0);
        check("t3_reports", 256'(rep_cnt - r0), 256'd0);
        send_pkt(2'b01, 4'd3, 1, 6'd20, 1'b1);
        wait_idle();
        check("t3_next_len", 256'(last_len), 256'd20);

        // Sop arrives mid-packet.
        r0 = rep_cnt;
        send_pkt(2'b01, 4'd7, 2, 6'd1, 1'b0);
        send_pkt(2'b01, 4'd8, 1, 6'd7, 1'b1);
        wait_idle();
        check("t4_code", 256'(last_err), 256'd3);
        check("t4_reports", 256'(rep_cnt - r0), 256'd1);
        check("t4_len", 256'(last_len), 256'd7);

        // Stray non-sop beat in idle.
        drive_beat(rand256(), 1'b0, 1'b1, 6'd4);
        wait_idle();
        check("t5_code", 256'(last_err), 256'd2);

        // Mid-packet reset: partial packet is never reported.
        send_pkt(2'b01, 4'd4, 2, 6'd1, 1'b0);
        repeat (2) @(negedge clock);
        do_reset();
        r0 = rep_cnt;
        send_pkt(2'b01, 4'd4, 1, 6'd32, 1'b1);
        wait_idle();
        check("t6_reports", 256'(rep_cnt - r0), 256'd1);
        check("t6_cnt", 256'(m_cnt), 256'd1);

        // placeFull toggling during an 8-beat packet.
        p0 = push_cnt;
        full_mode = 1;
        send_pkt(2'b01, 4'd11, 7, 6'd17, 1'b1);
        full_mode = 0;
        wait_idle();
        check("t7_pushes", 256'(push_cnt - p0), 256'd7);
        check("t7_len", 256'(last_len), 256'd209);

        // Random traffic on the default instance.
        full_mode = 2; rdy_mode = 1;
        for (int k = 0; k < 40; k++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0) drive_beat(rand256(), 1'b0, 1'($urandom_range(0, 1)), 6'd5);
            else send_pkt(($urandom_range(0, 5) == 0) ? 2'($urandom()) : 2'b01, 4'($urandom()),
                          $urandom_range(0, 8), 6'($urandom_range(1, 32)), r != 1);
        end
        full_mode = 0; rdy_mode = 0;
        send_pkt(2'b01, 4'd1, 0, 6'd1, 1'b1);
        wait_idle();

        // Overlength on the 64-byte instance.
        sel = 1'b1;
        do_reset();
        p0 = push_cnt; r0 = rep_cnt;
        send_pkt(2'b01, 4'd6, 4, 6'd32, 1'b1);
        wait_idle();
        check("t8_pushes", 256'(push_cnt - p0), 256'd2);
        check("t8_code", 256'(last_err), 256'd4);
        check("t8_reports", 256'(rep_cnt - r0), 256'd0);

        // Random traffic on the 64-byte instance.
        full_mode = 2; rdy_mode = 1;
        for (int k = 0; k < 25; k++)
            send_pkt(2'b01, 4'($urandom()), $urandom_range(0, 4), 6'($urandom_range(1, 32)), 1'b1);
        full_mode = 0; rdy_mode = 0;
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
